// File: rtl/y86_pkg.sv
// Shared Y86-64 encoding definitions: icodes, register ids, instruction lengths,
// encoder FSM states and the regids/valC predicates also used by fetch.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;

    localparam logic [3:0] LEN_1  = 4'd1;
    localparam logic [3:0] LEN_2  = 4'd2;
    localparam logic [3:0] LEN_9  = 4'd9;
    localparam logic [3:0] LEN_10 = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EMIT    = 2'd1,
        ST_STOPPED = 2'd2
    } enc_state_e;

    function automatic logic need_regids(input logic [3:0] icode);
        return icode inside {I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_OPQ, I_PUSHQ, I_POPQ};
    endfunction

    function automatic logic need_valC(input logic [3:0] icode);
        return icode inside {I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_JXX, I_CALL};
    endfunction

endpackage

// File: rtl/y86_instr_len.sv
// Combinational Y86-64 instruction length from icode; valid_o flags icodes 0..B.
module y86_instr_len
    import y86_pkg::*;
(
    input  logic [3:0] icode_i,
    output logic [3:0] len_o,
    output logic       valid_o
);

    logic regids;
    logic valc;

    always_comb begin
        regids  = need_regids(icode_i);
        valc    = need_valC(icode_i);
        valid_o = (icode_i <= I_POPQ);
        len_o   = LEN_1;
        if (regids && valc) begin
            len_o = LEN_10;
        end else if (valc) begin
            len_o = LEN_9;
        end else if (regids) begin
            len_o = LEN_2;
        end
    end

endmodule

// File: rtl/y86_instr_encoder.sv
// Serialises one decoded Y86-64 instruction into byte writes at the write pointer.
// Optional macro ENC_HALT_STOP_EN: after a halt byte, park in STOPPED until load_en.
module y86_instr_encoder
    import y86_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 64,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        icode,
    input  logic [3:0]        ifun,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic [63:0]       valC,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              instr_done,
    output logic              err,
    output logic [ADDR_W-1:0] next_pc
);

    enc_state_e        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [79:0]       sr_q, sr_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
`ifdef ENC_HALT_STOP_EN
    logic              halt_q, halt_d;
`endif

    logic [3:0] len;
    logic       len_valid;

    y86_instr_len u_len (
        .icode_i (icode),
        .len_o   (len),
        .valid_o (len_valid)
    );

    assign in_ready   = rst_n && (state_q == ST_IDLE) && !load_en;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_data   = data_q;
    assign instr_done = done_q;
    assign err        = err_q;
    assign next_pc    = ptr_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
`ifdef ENC_HALT_STOP_EN
        halt_d  = halt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (load_en) begin
                    ptr_d = load_addr;
                end else if (in_valid) begin
                    if (len_valid) begin
                        // Bytes packed LSB-first so EMIT just shifts right one byte per cycle
                        sr_d    = {(need_regids(icode) ? {valC, rA, rB} : {8'h00, valC}), icode, ifun};
                        cnt_d   = len;
                        state_d = ST_EMIT;
`ifdef ENC_HALT_STOP_EN
                        halt_d  = (icode == I_HALT);
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_EMIT: begin
                we_d   = 1'b1;
                addr_d = ptr_q;
                data_d = sr_q[7:0];
                sr_d   = {8'h00, sr_q[79:8]};
                ptr_d  = ptr_q + ADDR_W'(1);
                cnt_d  = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    done_d  = 1'b1;
`ifdef ENC_HALT_STOP_EN
                    state_d = halt_q ? ST_STOPPED : ST_IDLE;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
            ST_STOPPED: begin
                if (load_en) begin
                    ptr_d   = load_addr;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= RESET_ADDR;
            cnt_q   <= '0;
            sr_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= RESET_ADDR;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef ENC_HALT_STOP_EN
            halt_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef ENC_HALT_STOP_EN
            halt_q  <= halt_d;
`endif
        end
    end

endmodule

// File: tb/tb_y86_instr_encoder.sv
// Randomized self-checking bench for y86_instr_encoder (64-bit and 8-bit pointer instances).
module tb_y86_instr_encoder;

    localparam logic [63:0] RST_A = 64'h0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_en = 1'b0;
    logic [63:0] load_addr = '0;
    logic        in_valid = 1'b0;
    logic [3:0]  icode = '0, ifun = '0, rA = '0, rB = '0;
    logic [63:0] valC = '0;

    logic        in_ready, mem_we, instr_done, err;
    logic [63:0] mem_addr, next_pc;
    logic [7:0]  mem_data;

    logic        in_ready8, mem_we8, instr_done8, err8;
    logic [7:0]  mem_addr8, next_pc8, mem_data8, load_addr8;

    assign load_addr8 = load_addr[7:0];

    always #5 clk = ~clk;

    y86_instr_encoder #(.ADDR_W(64), .RESET_ADDR(64'h0)) u_dut (
        .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
        .in_valid(in_valid), .in_ready(in_ready), .icode(icode), .ifun(ifun),
        .rA(rA), .rB(rB), .valC(valC), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_data(mem_data), .instr_done(instr_done), .err(err), .next_pc(next_pc)
    );

    y86_instr_encoder #(.ADDR_W(8), .RESET_ADDR(8'h00)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr8),
        .in_valid(in_valid), .in_ready(in_ready8), .icode(icode), .ifun(ifun),
        .rA(rA), .rB(rB), .valC(valC), .mem_we(mem_we8), .mem_addr(mem_addr8),
        .mem_data(mem_data8), .instr_done(instr_done8), .err(err8), .next_pc(next_pc8)
    );

    int unsigned total = 0;
    int unsigned bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of the byte writes each accepted instruction must produce
    typedef struct {
        logic [63:0] addr;
        logic [7:0]  data;
        bit          last;
        bit          halt;
    } wr_t;

    wr_t         wq[$];
    logic [63:0] m_pc = RST_A;
    bit          m_stop = 0;
    bit          e_we = 0, e_done = 0, e_err = 0;
    logic [63:0] e_addr = '0;
    logic [7:0]  e_data = '0;

    logic [7:0]  mem64 [logic [63:0]];
    logic [7:0]  mem8  [logic [7:0]];
    int unsigned nwr = 0, ndone = 0, nerr = 0;

    always @(negedge clk) begin : model
        wr_t        w;
        bit         rdy, nr, nc;
        logic [7:0] bb [10];
        int         n;
        if (!rst_n) begin
            wq.delete();
            m_pc = RST_A; m_stop = 0;
            e_we = 0; e_done = 0; e_err = 0;
            chk("rst_we",    64'(mem_we), 64'(0));
            chk("rst_done",  64'(instr_done), 64'(0));
            chk("rst_err",   64'(err), 64'(0));
            chk("rst_addr",  mem_addr, RST_A);
            chk("rst_data",  64'(mem_data), 64'(0));
            chk("rst_pc",    next_pc, RST_A);
            chk("rst_ready", 64'(in_ready), 64'(0));
            chk("rst_we8",   64'(mem_we8), 64'(0));
            chk("rst_pc8",   64'(next_pc8), 64'(RST_A[7:0]));
        end else begin
            rdy = (wq.size() == 0) && !m_stop && !load_en;
            chk("we",    64'(mem_we), 64'(e_we));
            chk("done",  64'(instr_done), 64'(e_done));
            chk("err",   64'(err), 64'(e_err));
            chk("pc",    next_pc, m_pc);
            chk("ready", 64'(in_ready), 64'(rdy));
            chk("we8",   64'(mem_we8), 64'(e_we));
            chk("done8", 64'(instr_done8), 64'(e_done));
            chk("err8",  64'(err8), 64'(e_err));
            chk("pc8",   64'(next_pc8), 64'(m_pc[7:0]));
            chk("ready8", 64'(in_ready8), 64'(rdy));
            if (e_we) begin
                chk("addr",  mem_addr, e_addr);
                chk("data",  64'(mem_data), 64'(e_data));
                chk("addr8", 64'(mem_addr8), 64'(e_addr[7:0]));
                chk("data8", 64'(mem_data8), 64'(e_data));
            end
            if (mem_we) begin mem64[mem_addr] = mem_data; nwr++; end
            if (mem_we8) mem8[mem_addr8] = mem_data8;
            if (instr_done) ndone++;
            if (err) nerr++;

            // predict outputs after the coming rising edge
            e_we = 0; e_done = 0; e_err = 0;
            if (wq.size() > 0) begin
                w = wq.pop_front();
                e_we = 1; e_addr = w.addr; e_data = w.data; e_done = w.last;
                m_pc = w.addr + 64'd1;
`ifdef ENC_HALT_STOP_EN
                if (w.last && w.halt) m_stop = 1;
`endif
            end else if (m_stop) begin
                if (load_en) begin m_pc = load_addr; m_stop = 0; end
            end else if (load_en) begin
                m_pc = load_addr;
            end else if (in_valid) begin
                if (icode > 4'hB) begin
                    e_err = 1;
                end else begin
                    nr = icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
                    nc = icode inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
                    n = 0;
                    bb[n] = {icode, ifun}; n++;
                    if (nr) begin bb[n] = {rA, rB}; n++; end
                    if (nc) for (int i = 0; i < 8; i++) begin bb[n] = valC[8*i +: 8]; n++; end
                    for (int i = 0; i < n; i++)
                        wq.push_back('{m_pc + 64'(i), bb[i], (i == n - 1), (icode == 4'h0)});
                end
            end
        end
    end

    task automatic scramble();
        icode = 4'($urandom); ifun = 4'($urandom); rA = 4'($urandom); rB = 4'($urandom);
        valC = {$urandom, $urandom};
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk); #1;
            if (wq.size() == 0) ok = 1;
        end
        if (!ok) chk("idle_timeout", 64'(1), 64'(0));
        repeat (2) @(negedge clk);
    endtask

    task automatic load(input logic [63:0] a);
        @(posedge clk); #1 load_en = 1'b1; load_addr = a;
        @(posedge clk); #1 load_en = 1'b0; load_addr = {$urandom, $urandom};
    endtask

    task automatic send(input logic [3:0] ic, input logic [3:0] f, input logic [3:0] a,
                        input logic [3:0] b, input logic [63:0] c);
        bit ok = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; icode = ic; ifun = f; rA = a; rB = b; valC = c;
        for (int k = 0; k < 60 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
        end
        if (!ok) chk("send_timeout", 64'(1), 64'(0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [7:0]  exp1 [10];
        int unsigned b0, b1, r;
        logic [3:0]  ic;
        exp1 = '{8'h30, 8'hF2, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};

        // halt then nop from reset
        do_reset();
        @(negedge clk); #1;
        chk("rst_pc_lit", next_pc, 64'h0);
        chk("rst_ready_lit", 64'(in_ready), 64'(1));
        mem64.delete(); b0 = ndone;
        send(4'h0, 4'h0, 4'hF, 4'hF, 64'h0);
        @(negedge clk); chk("t2_gap", 64'(in_ready), 64'(0));
`ifdef ENC_HALT_STOP_EN
        repeat (3) begin @(negedge clk); chk("t6_stopped", 64'(in_ready), 64'(0)); end
        load(64'h1);
`else
        @(negedge clk); chk("t2_back", 64'(in_ready), 64'(1));
`endif
        send(4'h1, 4'h0, 4'hF, 4'hF, 64'h0);
        wait_idle();
        chk("t2_b0", 64'(mem64[64'h0]), 64'h00);
        chk("t2_b1", 64'(mem64[64'h1]), 64'h10);
        chk("t2_done", 64'(ndone - b0), 64'd2);
        chk("t2_pc", next_pc, 64'h2);

        // irmovq at 0x100
        mem64.delete(); b0 = ndone;
        load(64'h100);
        send(4'h3, 4'h0, 4'hF, 4'h2, 64'h0123456789ABCDEF);
        wait_idle();
        for (int i = 0; i < 10; i++) chk("t1_byte", 64'(mem64[64'h100 + 64'(i)]), 64'(exp1[i]));
        chk("t1_done", 64'(ndone - b0), 64'd1);
        chk("t1_pc", next_pc, 64'h10A);

        // jXX at 0x20
        mem64.delete();
        load(64'h20);
        send(4'h7, 4'h3, 4'hF, 4'hF, 64'h40);
        wait_idle();
        chk("t3_b0", 64'(mem64[64'h20]), 64'h73);
        chk("t3_b1", 64'(mem64[64'h21]), 64'h40);
        for (int i = 2; i < 9; i++) chk("t3_bz", 64'(mem64[64'h20 + 64'(i)]), 64'h00);
        chk("t3_pc", next_pc, 64'h29);

        // invalid icode
        b0 = nwr; b1 = nerr;
        send(4'hC, 4'h5, 4'h1, 4'h2, 64'h1234);
        repeat (3) @(negedge clk);
        chk("t4_nowrite", 64'(nwr - b0), 64'd0);
        chk("t4_err", 64'(nerr - b1), 64'd1);
        chk("t4_pc", next_pc, 64'h29);
        chk("t4_ready", 64'(in_ready), 64'(1));

        // pointer wrap on the 8-bit instance
        mem8.delete();
        load(64'hFE);
        send(4'h2, 4'h0, 4'h1, 4'h3, 64'h0);
        send(4'h6, 4'h0, 4'h4, 4'h5, 64'h0);
        wait_idle();
        chk("t5_fe", 64'(mem8[8'hFE]), 64'h20);
        chk("t5_ff", 64'(mem8[8'hFF]), 64'h13);
        chk("t5_00", 64'(mem8[8'h00]), 64'h60);
        chk("t5_01", 64'(mem8[8'h01]), 64'h45);
        chk("t5_pc8", 64'(next_pc8), 64'h02);
        chk("t5_pc64", next_pc, 64'h102);

        // randomized traffic
        for (int it = 0; it < 80; it++) begin
            r = $urandom_range(0, 99);
            if (r < 15) begin
                load({$urandom, $urandom});
            end else begin
                ic = (r < 25) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
                send(ic, 4'($urandom), 4'($urandom), 4'($urandom), {$urandom, $urandom});
                if (r > 90) load({$urandom, $urandom});
`ifdef ENC_HALT_STOP_EN
                if (ic == 4'h0) begin wait_idle(); load({$urandom, $urandom}); end
`endif
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        wait_idle();

        // reset in the middle of irmovq
        do_reset();
        b0 = nwr; b1 = ndone;
        send(4'h3, 4'h0, 4'hF, 4'h2, {$urandom, $urandom});
        begin
            bit got = 0;
            for (int k = 0; k < 30 && !got; k++) begin
                @(negedge clk); #1;
                if (nwr - b0 >= 3) got = 1;
            end
            if (!got) chk("t6_timeout", 64'(1), 64'(0));
        end
        #1 rst_n = 1'b0;
        #1;
        chk("t6_we", 64'(mem_we), 64'(0));
        chk("t6_we8", 64'(mem_we8), 64'(0));
        chk("t6_done", 64'(instr_done), 64'(0));
        chk("t6_pc", next_pc, RST_A);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); #1;
        chk("t6_ready", 64'(in_ready), 64'(1));
        chk("t6_nwr", 64'(nwr - b0), 64'd3);
        chk("t6_ndone", 64'(ndone - b1), 64'd0);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
